cpu_trace_buffer: RTL and testbench
===================================

// Module: cpu_trace_buffer
// PURPOSE
//  Downstream observer of the 4-bit CPU core. Each cycle it samples the core's pc_out,
//  reg0..reg3_out and halt. It pushes change-only snapshots, each tagged with a cycle
//  stamp, into a FIFO that a bench or debug port drains through a valid/ready handshake.
//  Capture freezes once the core halts, so the trace ends on the halting state.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >=2
//  PC_W    4   PC width; matches the core
//  DATA_W  4   register width; matches the core
//  CNT_W   8   cycle-stamp and drop-counter width
// PORTS
//  clk       in   1                      rising-edge clock, shared with the core
//  rst       in   1                      synchronous, active-low reset (0 = reset)
//  en        in   1                      capture enable
//  clear     in   1                      sync flush: empty FIFO, zero counters, go to IDLE
//  halt      in   1                      core halt flag
//  pc_in     in   PC_W                   core PC
//  reg0_in   in   DATA_W                 core R0 (reg1_in..reg3_in identical, R1..R3)
//  rd_valid  out  1                      rd_data holds the oldest entry
//  rd_ready  in   1                      consumer accepts; pop when rd_valid&rd_ready
//  rd_data   out  CNT_W+1+PC_W+4*DATA_W  {stamp, halt, pc, r3, r2, r1, r0}
//  level     out  $clog2(DEPTH)+1        current occupancy
//  full      out  1                      level==DEPTH
//  overflow  out  1                      sticky: a snapshot was dropped
//  drop_cnt  out  CNT_W                  dropped snapshots, saturating
//  frozen    out  1                      high in FROZEN state
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE. FIFO empty, level=0, rd_valid=0, rd_data=0,
//   full=0, overflow=0, drop_cnt=0, stamp=0, frozen=0. Reset mid-operation discards all entries.
//  FSM (registered):
//   IDLE->CAPTURE when en=1; stamp<=0; first-sample flag set.
//   CAPTURE->IDLE when en=0; FIFO contents retained and still readable.
//   CAPTURE->FROZEN on the cycle a snapshot with halt=1 is offered (pushed or dropped).
//   FROZEN: no captures, reads continue. FROZEN->IDLE only on clear.
//   clear has priority over en and halt in every state.
//  Capture (CAPTURE only): the snapshot is offered when the first-sample flag is set
//   or {halt,pc,r0..r3} differs from the last offered snapshot. The comparison register
//   updates on every offer, including dropped ones.
//  Stamp: counts cycles since entry to CAPTURE; saturates at 2^CNT_W-1, never wraps.
//  Latency: snapshot sampled at edge N -> rd_valid/rd_data visible after edge N+1
//   (1 cycle). rd_data is driven from the FIFO head register; there is no
//   combinational in->out path.
//  Handshake: rd_data is stable while rd_valid=1 and rd_ready=0. Pop occurs only on
//   rd_valid&rd_ready. rd_ready while empty has no effect.
//  Full: an offered snapshot is dropped when full and no pop happens that cycle.
//   A drop sets overflow and increments drop_cnt, which saturates.
//   Push and pop in the same cycle while full: both succeed, level unchanged.
//   Push and pop in the same cycle at level 1: head takes the new entry, rd_valid stays 1.
//  Pointers: log2(DEPTH) bits, natural wrap. level is tracked separately to tell full from empty.
//  full, level and rd_valid are registered and consistent in the same cycle.
// STRUCTURE
//  cpu_trace_pkg: state encodings (IDLE/CAPTURE/FROZEN) and the ENTRY_W localparam.
//   It also defines the field offsets of rd_data (STAMP_LSB, HALT_BIT, PC_LSB, R0_LSB).
//  Sub-module trace_fifo: sync FIFO (DEPTH x ENTRY_W) with push/pop, level, full and
//   empty outputs. The top level holds the FSM, change detector, stamp and drop logic.
// TESTING
//  1 Reset: hold rst=0 for 2 cycles with en=1 and changing inputs -> all outputs 0;
//    level=0 after release.
//  2 Change-only: en=1, pc steps 0,1,1,2 (regs constant) -> 3 entries with pc 0,1,2
//    and stamps 0,1,3.
//  3 Halt freeze: halt rises with pc=5 at stamp 7 -> last entry {7,1,5,...}; frozen=1;
//    later pc changes are not captured.
//  4 Overflow: DEPTH=16, rd_ready=0, 20 distinct pcs -> full=1, level=16,
//    drop_cnt=4, overflow=1; the first 16 are read back in order.
//  5 Backpressure: toggle rd_ready 1/0 while capturing -> rd_data is stable while
//    stalled, no loss or duplication, and a simultaneous push+pop at full keeps level=16.
//  6 Clear mid-capture: 5 entries queued, pulse clear -> level=0, rd_valid=0,
//    state IDLE, drop_cnt=0; en still high -> CAPTURE on the next cycle, stamp restarts at 0.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared state encoding, default widths and rd_data field offsets
// for the CPU trace buffer.
//   state_t    IDLE / CAPTURE / FROZEN
//   ENTRY_W    width of one trace entry {stamp, halt, pc, r3, r2, r1, r0}
//   *_LSB/BIT  bit positions of each field inside rd_data (default widths)
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FROZEN  = 2'd2
    } state_t;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_PC_W   = 4;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_CNT_W  = 8;

    localparam int R0_LSB    = 0;
    localparam int PC_LSB    = 4 * DEF_DATA_W;
    localparam int HALT_BIT  = PC_LSB + DEF_PC_W;
    localparam int STAMP_LSB = HALT_BIT + 1;
    localparam int ENTRY_W   = STAMP_LSB + DEF_CNT_W;

endpackage

// File: rtl/cpu_trace_buffer_fifo.sv
// trace_fifo: synchronous DEPTH x W FIFO with registered level/full/empty.
//   clk, rst (sync, active-low), clr (sync flush)
//   push/din  write request and data; accepted when not full or popping
//   pop       read request; ignored while empty
//   dout      oldest entry (zero while empty)
//   level, full, empty  registered occupancy status
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 29
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [AW:0]   level_nxt;

    // A push into a full FIFO is allowed when the same cycle frees a slot.
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign level_nxt = level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    assign dout      = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            full  <= level_nxt == FULL_LVL;
            empty <= level_nxt == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: change-only trace recorder for the 4-bit CPU core.
//   clk, rst (sync, active-low), en (capture enable), clear (sync flush)
//   halt, pc_in, reg0_in..reg3_in   core state observed every cycle
//   rd_valid/rd_ready/rd_data       drain handshake, rd_data = {stamp,halt,pc,r3,r2,r1,r0}
//   level, full                     FIFO occupancy
//   overflow, drop_cnt              sticky drop flag and saturating drop count
//   frozen                          capture stopped after a halting snapshot
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PC_W   = DEF_PC_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              clear,
    input  logic                              halt,
    input  logic [PC_W-1:0]                   pc_in,
    input  logic [DATA_W-1:0]                 reg0_in,
    input  logic [DATA_W-1:0]                 reg1_in,
    input  logic [DATA_W-1:0]                 reg2_in,
    input  logic [DATA_W-1:0]                 reg3_in,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [CNT_W+PC_W+4*DATA_W:0]      rd_data,
    output logic [$clog2(DEPTH):0]            level,
    output logic                              full,
    output logic                              overflow,
    output logic [CNT_W-1:0]                  drop_cnt,
    output logic                              frozen
);

    localparam int SW = 1 + PC_W + 4 * DATA_W;
    localparam int EW = CNT_W + SW;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] snap;
    logic [SW-1:0] last;
    logic [CNT_W-1:0] stamp;
    logic          first;
    logic          offer;
    logic          pop;
    logic          drop;
    logic          fifo_empty;

    // Core state is registered first, so a sample taken at one edge is
    // compared and pushed at the next one.
    assign offer    = state == CAPTURE && !clear && (first || snap != last);
    assign pop      = rd_valid && rd_ready;
    assign drop     = offer && full && !pop;
    assign rd_valid = !fifo_empty;
    assign frozen   = state == FROZEN;

    always_comb begin
        state_nxt = clear                                     ? IDLE    :
                    (state == IDLE && en)                     ? CAPTURE :
                    (state == CAPTURE && offer && snap[SW-1]) ? FROZEN  :
                    (state == CAPTURE && !en)                 ? IDLE    :
                                                                state;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            snap     <= '0;
            last     <= '0;
            first    <= 1'b0;
            stamp    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            snap <= {halt, pc_in, reg3_in, reg2_in, reg1_in, reg0_in};
            if (clear) begin
                first    <= 1'b0;
                stamp    <= '0;
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else begin
                if (state == IDLE && en) begin
                    first <= 1'b1;
                    stamp <= '0;
                end else if (state == CAPTURE) begin
                    stamp <= (&stamp) ? stamp : stamp + 1'b1;
                end
                // Dropped offers still update the reference so the next
                // change is measured against what the core actually did.
                if (offer) begin
                    last  <= snap;
                    first <= 1'b0;
                end
                if (drop) begin
                    overflow <= 1'b1;
                    drop_cnt <= (&drop_cnt) ? drop_cnt : drop_cnt + 1'b1;
                end
            end
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .push  (offer),
        .pop   (pop),
        .din   ({stamp, snap}),
        .dout  (rd_data),
        .level (level),
        .full  (full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed scoreboard bench for cpu_trace_buffer.
module tb_cpu_trace_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        clear = 1'b0;
    logic        halt = 1'b0;
    logic [3:0]  pc = 4'd0;
    logic [3:0]  r0 = 4'h3;
    logic [3:0]  r1 = 4'h5;
    logic [3:0]  r2 = 4'h7;
    logic [3:0]  r3 = 4'h9;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [28:0] rd_data;
    logic [4:0]  level;
    logic        full;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        frozen;

    int checks = 0;
    int errors = 0;
    logic [28:0] exp_q[$];

    always #5 clk = ~clk;

    cpu_trace_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clear    (clear),
        .halt     (halt),
        .pc_in    (pc),
        .reg0_in  (r0),
        .reg1_in  (r1),
        .reg2_in  (r2),
        .reg3_in  (r3),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .level    (level),
        .full     (full),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .frozen   (frozen)
    );

    function automatic logic [28:0] ent(input logic [7:0] s, input logic h, input logic [3:0] p);
        return {s, h, p, r3, r2, r1, r0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: pops and scores the head when a transfer is due, and
    // checks that a stalled head is held across the edge.
    task automatic tick();
        logic        stalled;
        logic [28:0] hold;
        stalled = rd_valid === 1'b1 && !rd_ready && !clear && rst;
        hold    = rd_data;
        if (rd_valid === 1'b1 && rd_ready) begin
            if (exp_q.size() == 0) chk("valid_with_empty_scoreboard", 64'(rd_valid), 64'd0);
            else                   chk("pop_data", 64'(rd_data), 64'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
        if (stalled) chk("stall_hold", 64'(rd_data), 64'(hold));
    endtask

    task automatic drain();
        int n = 0;
        rd_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("drain_valid", 64'(rd_valid), 64'd0);
        rd_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with activity on the inputs
        en = 1'b1; pc = 4'd3; tick();
        pc = 4'd7; halt = 1'b1; tick();
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_frozen", 64'(frozen), 64'd0);
        rst = 1'b1; en = 1'b0; halt = 1'b0; tick();
        chk("post_rst_level", 64'(level), 64'd0);

        // Change-only capture and one-cycle latency
        en = 1'b1; pc = 4'd0; exp_q.push_back(ent(8'd0, 1'b0, 4'd0)); tick();
        chk("lat_edge0_valid", 64'(rd_valid), 64'd0);
        pc = 4'd1; exp_q.push_back(ent(8'd1, 1'b0, 4'd1)); tick();
        chk("lat_edge1_valid", 64'(rd_valid), 64'd1);
        chk("lat_edge1_data", 64'(rd_data), 64'(exp_q[0]));
        pc = 4'd1; tick();
        pc = 4'd2; exp_q.push_back(ent(8'd3, 1'b0, 4'd2)); tick();
        en = 1'b0; tick();
        chk("change_level", 64'(level), 64'd3);
        drain();

        // Halt freezes the trace on the halting snapshot
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pc   = k < 5 ? 4'(k) : (k == 7 ? 4'd5 : 4'd4);
            halt = k == 7;
            if (k < 5)  exp_q.push_back(ent(8'(k), 1'b0, 4'(k)));
            if (k == 7) exp_q.push_back(ent(8'd7, 1'b1, 4'd5));
            tick();
        end
        pc = 4'd6; tick();
        chk("halt_frozen", 64'(frozen), 64'd1);
        pc = 4'd7; halt = 1'b0; tick();
        pc = 4'd8; tick();
        chk("halt_level", 64'(level), 64'd6);
        en = 1'b0; drain();
        chk("halt_still_frozen", 64'(frozen), 64'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_unfreeze", 64'(frozen), 64'd0);

        // Overflow: 20 distinct snapshots into a 16-deep FIFO
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            pc = 4'(k);
            if (k < 16) exp_q.push_back(ent(8'(k), 1'b0, 4'(k)));
            tick();
        end
        en = 1'b0; tick();
        chk("ovf_full", 64'(full), 64'd1);
        chk("ovf_level", 64'(level), 64'd16);
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd4);
        chk("ovf_flag", 64'(overflow), 64'd1);
        drain();
        rd_ready = 1'b1; tick(); tick(); rd_ready = 1'b0;
        chk("ready_empty_level", 64'(level), 64'd0);
        chk("ready_empty_valid", 64'(rd_valid), 64'd0);

        // Clear mid-capture with drop counter still non-zero
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pc = 4'(k); exp_q.push_back(ent(8'(k), 1'b0, 4'(k))); tick();
        end
        tick();
        chk("pre_clear_level", 64'(level), 64'd5);
        clear = 1'b1; tick(); clear = 1'b0;
        exp_q.delete();
        chk("clear_level", 64'(level), 64'd0);
        chk("clear_valid", 64'(rd_valid), 64'd0);
        chk("clear_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("clear_overflow", 64'(overflow), 64'd0);
        pc = 4'd9; exp_q.push_back(ent(8'd0, 1'b0, 4'd9)); tick();
        tick();
        chk("restart_data", 64'(rd_data), 64'(exp_q[0]));
        en = 1'b0; tick();
        drain();

        // Backpressure: ready toggles while a change arrives every other cycle
        clear = 1'b1; tick(); clear = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 24; k++) begin
            pc = 4'(k / 2);
            rd_ready = (k % 2) == 1;
            if ((k % 2) == 0) exp_q.push_back(ent(8'(k), 1'b0, 4'(k / 2)));
            tick();
        end
        en = 1'b0; rd_ready = 1'b0; tick();
        drain();
        chk("bp_drop_cnt", 64'(drop_cnt), 64'd0);

        // Simultaneous push and pop while full
        clear = 1'b1; tick(); clear = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 17; k++) begin
            pc = 4'(k);
            exp_q.push_back(ent(8'(k), 1'b0, 4'(k)));
            tick();
        end
        chk("full_pre_level", 64'(level), 64'd16);
        en = 1'b0; rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        chk("full_pp_level", 64'(level), 64'd16);
        chk("full_pp_full", 64'(full), 64'd1);
        chk("full_pp_drop_cnt", 64'(drop_cnt), 64'd0);
        drain();

        // Stamp saturation, with the change carried by a register only
        clear = 1'b1; tick(); clear = 1'b0;
        en = 1'b1; pc = 4'd0; exp_q.push_back(ent(8'd0, 1'b0, 4'd0)); tick();
        for (int k = 1; k < 300; k++) tick();
        r2 = 4'hE; exp_q.push_back(ent(8'hFF, 1'b0, 4'd0)); tick();
        en = 1'b0; tick();
        chk("sat_level", 64'(level), 64'd2);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
